// File: rtl/obus_dout_arb.sv
// Outbound data bus arbiter: round-robin packet-locked grant between N requesters,
// with a registered beat that doubles as the replay buffer for the want/can/replay handshake.
module obus_dout_arb #(
  parameter int N      = 4,
  parameter int DATA_W = 568,
  parameter int SIG_W  = 76,
  parameter int MAXRP  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_want,
  input  logic [N*DATA_W-1:0] req_data,
  input  logic [N*SIG_W-1:0]  req_sig,
  input  logic [N-1:0]        req_last,
  output logic [N-1:0]        req_ack,
  output logic [DATA_W-1:0]   obusDOut_data,
  output logic [SIG_W-1:0]    obusDOut_iosig,
  output logic                obusDOut_want,
  input  logic                obusDOut_can,
  input  logic                obusDOut_replay,
  output logic                busy,
  output logic                rp_err
);

  localparam int OW = $clog2(N);
  localparam int RW = $clog2(MAXRP + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t        state;
  logic          lock;
  logic          out_last;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] owner;
  logic [RW-1:0] rp_cnt;

  logic [OW-1:0] cand;
  logic [OW-1:0] pick;
  logic          pick_valid;
  logic [OW-1:0] load_idx;
  logic          load;

  always_comb begin
    cand       = '0;
    pick       = owner;
    pick_valid = 1'b0;
    if (lock) begin
      pick_valid = req_want[owner];
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = OW'((32'(rr_ptr) + k) % unsigned'(N));
        if (!pick_valid && req_want[cand]) begin
          pick_valid = 1'b1;
          pick       = cand;
        end
      end
    end

    // A new beat enters the output register either from an IDLE pick or
    // directly from the owner once the previous beat closes its replay window.
    load     = 1'b0;
    load_idx = pick;
    case (state)
      IDLE: load = pick_valid;
      WAIT: if (!obusDOut_replay && !out_last && req_want[owner]) begin
        load     = 1'b1;
        load_idx = owner;
      end
      default: ;
    endcase
    if (rst) load = 1'b0;

    req_ack = '0;
    if (load) req_ack[load_idx] = 1'b1;
  end

  assign busy = lock | (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lock           <= 1'b0;
      out_last       <= 1'b0;
      rr_ptr         <= '0;
      owner          <= '0;
      rp_cnt         <= '0;
      rp_err         <= 1'b0;
      obusDOut_want  <= 1'b0;
      obusDOut_data  <= '0;
      obusDOut_iosig <= '0;
    end else begin
      if (load) begin
        obusDOut_data  <= req_data[int'(load_idx)*DATA_W +: DATA_W];
        obusDOut_iosig <= req_sig[int'(load_idx)*SIG_W +: SIG_W];
        out_last       <= req_last[load_idx];
        owner          <= load_idx;
        lock           <= 1'b1;
        state          <= SEND;
        obusDOut_want  <= 1'b1;
      end
      case (state)
        SEND: if (obusDOut_can) begin
          state         <= WAIT;
          obusDOut_want <= 1'b0;
        end
        WAIT: if (obusDOut_replay) begin
          state         <= SEND;
          obusDOut_want <= 1'b1;
          if (rp_cnt != RW'(MAXRP)) rp_cnt <= rp_cnt + RW'(1);
          if (rp_cnt >= RW'(MAXRP - 1)) rp_err <= 1'b1;
        end else begin
          rp_cnt <= '0;
          if (out_last) begin
            lock   <= 1'b0;
            rr_ptr <= (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
            state  <= IDLE;
          end else if (!load) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/obus_dout_arb.md
# obus_dout_arb

Arbiter and sequencer for the core's outbound data bus (obusDOut). It shares the bus between up to N on-core requesters, such as dcache writeback, store-merge and IO responses. Multi-beat packets are never interleaved. The block owns the bus-side want/can/replay handshake, including re-sending a beat when the bus signals replay. It sits between the memory back end and the core's obusDOut ports.

## Interface
- N, 4: number of requesters (2..8).
- DATA_W, 568: beat data width (512 data + 56 ECC).
- SIG_W, 76: iosig width per beat.
- MAXRP, 15: consecutive replays of one beat before the error flag sets.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_want  in  N  requester i has a beat presented.
- req_data  in  N*DATA_W  beat data, slice i.
- req_sig  in  N*SIG_W  beat iosig, slice i.
- req_last  in  N  beat i is the last beat of its packet.
- req_ack  out  N  one-cycle pulse: beat of requester i has been captured; requester may present its next beat the following cycle.
- obusDOut_data  out  DATA_W  registered beat data.
- obusDOut_iosig  out  SIG_W  registered beat iosig.
- obusDOut_want  out  1  beat valid on bus.
- obusDOut_can  in  1  bus accepts beat this cycle.
- obusDOut_replay  in  1  beat transferred last cycle must be resent.
- busy  out  1  a packet is in progress (lock held or beat in flight).
- rp_err  out  1  sticky: MAXRP consecutive replays seen on one beat.

## Operation
- Output register: out_data, out_sig, out_owner (log2 N), out_last. It doubles as the replay buffer; data stays until the replay window closes.
- States:
  - IDLE: out empty.
  - SEND: want=1.
  - WAIT: replay window, want=0.
- IDLE:
  - Candidates: if lock is set, only owner; otherwise all i with req_want[i].
  - Unlocked pick: round-robin, first requesting index at or after rr_ptr, wrapping mod N.
  - On pick: load out register, pulse req_ack[pick], set owner=pick, set lock=1, go to SEND.
- SEND: when obusDOut_can=1, the transfer occurs; go to WAIT.
- WAIT, obusDOut_replay=1:
  - Go to SEND with the same register contents.
  - rp_cnt increments, saturating at MAXRP.
  - rp_cnt reaching MAXRP sets rp_err.
- WAIT, replay=0: beat is complete; rp_cnt=0.
  - If out_last: lock=0, rr_ptr=(owner+1) mod N, go to IDLE.
  - Else if req_want[owner]: load the next beat directly, pulse req_ack[owner], go to SEND.
  - Else: go to IDLE with lock held.
- Non-owner requests are ignored while lock is held.
- A requester may drop req_want mid-packet; the lock persists until its last beat completes.
- busy = lock | (state≠IDLE).
- replay or can in IDLE is ignored; replay in SEND is ignored.
- rp_err clears only on rst.

## Timing
- Reset, asynchronous: state=IDLE, lock=0, rr_ptr=0, owner=0, rp_cnt=0, rp_err=0, obusDOut_want=0, obusDOut_data=0, obusDOut_iosig=0, req_ack=0, busy=0.
- Reset asserted mid-packet abandons the beat with no ack or replay afterward; requesters must also reset.
- req_ack is combinational from state and inputs. It is asserted in the same cycle the beat is loaded (IDLE pick, or WAIT with no replay and not last).
- Latency: request in IDLE at cycle T → ack at T → want=1 at T+1.
- Peak throughput: 1 beat per 2 cycles (SEND, WAIT) with can held at 1.
- Replay is sampled only in WAIT, the cycle right after the transfer. Resend appears with want=1 one cycle later.
- Single-beat packet, can=1: ack T, transfer T+1, WAIT T+2, IDLE T+3. The next requester is acked at T+3.

## Test plan
- Single requester, 1-beat packet, can=1: ack at T, want at T+1 with data, want=0 at T+2, busy=0 at T+3.
- Req 0, 2 and 3 all want 1-beat packets from reset: grants in order 0,2,3. rr_ptr=0 after 3; req 0 is served first when it requests again.
- Req 1 sends a 3-beat packet while req 0 wants continuously: all 3 req1 beats go out back-to-back (every 2 cycles), then req 0 is served.
- can=0 held for 10 cycles in SEND: want stays 1 with stable data, no ack. Transfer occurs on the first cycle can=1.
- replay=1 in WAIT twice: identical beat re-driven twice, no extra ack, rp_err=0. Then 15 consecutive replays set rp_err, which stays set.
- rst asserted mid-packet in SEND: want=0 and all outputs at reset values immediately. After release, a new request from any index is granted.
